// File: rtl/rx_ts_queue_if.sv
// rx_ts_queue_if: capture inputs and software queue port of the rx timestamp queue
interface rx_ts_queue_if #(parameter int ADDR_W = 2);
  logic          q_en_i;
  logic [15:0]   msg_type_mask_i;
  logic          rxts_trig_i;
  logic          rxts_valid_i;
  logic [79:0]   sfd_timestamp_i;
  logic [79:0]   rx_sourcePortIdentity_i;
  logic [15:0]   rx_seqId_i;
  logic [3:0]    rx_messageType_i;
  logic [3:0]    rx_majorSdoId_i;
  logic          q_pop_i;
  logic          q_clr_i;
  logic          q_valid_o;
  logic [79:0]   q_timestamp_o;
  logic [79:0]   q_sourcePortIdentity_o;
  logic [15:0]   q_seqId_o;
  logic [3:0]    q_messageType_o;
  logic [3:0]    q_majorSdoId_o;
  logic [ADDR_W:0] q_count_o;
  logic [7:0]    q_drop_cnt_o;
  logic          q_overflow_o;
  logic          int_rx_ts_o;
  modport slave (
    input  q_en_i, msg_type_mask_i, rxts_trig_i, rxts_valid_i, sfd_timestamp_i,
           rx_sourcePortIdentity_i, rx_seqId_i, rx_messageType_i, rx_majorSdoId_i,
           q_pop_i, q_clr_i,
    output q_valid_o, q_timestamp_o, q_sourcePortIdentity_o, q_seqId_o, q_messageType_o,
           q_majorSdoId_o, q_count_o, q_drop_cnt_o, q_overflow_o, int_rx_ts_o
  );
  modport master (
    output q_en_i, msg_type_mask_i, rxts_trig_i, rxts_valid_i, sfd_timestamp_i,
           rx_sourcePortIdentity_i, rx_seqId_i, rx_messageType_i, rx_majorSdoId_i,
           q_pop_i, q_clr_i,
    input  q_valid_o, q_timestamp_o, q_sourcePortIdentity_o, q_seqId_o, q_messageType_o,
           q_majorSdoId_o, q_count_o, q_drop_cnt_o, q_overflow_o, int_rx_ts_o
  );
endinterface

// File: rtl/rx_ts_queue.sv
// rx_ts_queue: pairs latched SFD timestamps with PTP identity fields in a show-ahead queue for software
module rx_ts_queue #(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 255
) (
  input logic          rtc_clk,
  input logic          rtc_rst_n,
  rx_ts_queue_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int EW    = 184;
  typedef enum logic {IDLE, ARMED} state_t;
  state_t          state_q, state_d;
  logic [79:0]     ts_q, ts_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [ADDR_W:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]      drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            push, pop_ok, full, empty, wr_en, drop;
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    tmo_d   = tmo_q;
    if (state_q == ARMED) begin
      tmo_d = tmo_q - 8'd1;
      if (!bus.q_en_i || bus.rxts_valid_i || tmo_q <= 8'd1) begin
        state_d = IDLE;
        tmo_d   = '0;
      end
    end
    // a new SFD overrides any exit; a coincident valid still pushes the old timestamp
    if (bus.rxts_trig_i && bus.q_en_i) begin
      state_d = ARMED;
      ts_d    = bus.sfd_timestamp_i;
      tmo_d   = 8'(TIMEOUT);
    end
  end
  assign push   = state_q == ARMED && bus.rxts_valid_i && bus.q_en_i &&
                  bus.msg_type_mask_i[bus.rx_messageType_i];
  assign empty  = wr_q == rd_q;
  assign full   = wr_q[ADDR_W] != rd_q[ADDR_W] && wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0];
  assign pop_ok = bus.q_pop_i && !empty;
  assign wr_en  = push && (!full || pop_ok) && !bus.q_clr_i;
  assign drop   = push && full && !pop_ok;
  assign wr_d   = bus.q_clr_i ? '0 : wr_q + (ADDR_W+1)'(wr_en);
  assign rd_d   = bus.q_clr_i ? '0 : rd_q + (ADDR_W+1)'(pop_ok);
  assign drop_d = bus.q_clr_i ? '0 : drop_q + 8'(drop && drop_q != 8'hff);
  assign ovf_d  = !bus.q_clr_i && (ovf_q || drop);
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      state_q <= IDLE;
      ts_q    <= '0;
      tmo_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge rtc_clk)
    if (wr_en)
      mem[wr_q[ADDR_W-1:0]] <= {ts_q, bus.rx_sourcePortIdentity_i, bus.rx_seqId_i,
                                bus.rx_messageType_i, bus.rx_majorSdoId_i};
  // storage is not reset, so head fields are masked to zero while empty
  assign head                       = empty ? '0 : mem[rd_q[ADDR_W-1:0]];
  assign bus.q_valid_o              = !empty;
  assign bus.int_rx_ts_o            = !empty;
  assign bus.q_timestamp_o          = head[183:104];
  assign bus.q_sourcePortIdentity_o = head[103:24];
  assign bus.q_seqId_o              = head[23:8];
  assign bus.q_messageType_o        = head[7:4];
  assign bus.q_majorSdoId_o         = head[3:0];
  assign bus.q_count_o              = wr_q - rd_q;
  assign bus.q_drop_cnt_o           = drop_q;
  assign bus.q_overflow_o           = ovf_q;
endmodule

// File: tb/tb_rx_ts_queue.sv
// tb_rx_ts_queue: directed checks of capture FSM, timeout, masking and queue full/clear behaviour
module tb_rx_ts_queue;
  localparam int AW  = 2;
  localparam int TMO = 16;
  localparam logic [79:0] SPID = 80'hA1B2_C3D4_E5F6_0718_293A;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  rx_ts_queue_if #(.ADDR_W(AW)) bus ();
  rx_ts_queue #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (.rtc_clk(clk), .rtc_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [183:0] obs, input logic [183:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic trig(input logic [79:0] ts);
    bus.rxts_trig_i = 1'b1;
    bus.sfd_timestamp_i = ts;
    tick();
    bus.rxts_trig_i = 1'b0;
  endtask
  task automatic valid(input logic [15:0] seq, input logic [3:0] mt);
    bus.rxts_valid_i = 1'b1;
    bus.rx_seqId_i = seq;
    bus.rx_messageType_i = mt;
    bus.rx_majorSdoId_i = 4'h3;
    tick();
    bus.rxts_valid_i = 1'b0;
  endtask
  task automatic pop();
    bus.q_pop_i = 1'b1;
    tick();
    bus.q_pop_i = 1'b0;
  endtask
  task automatic clr();
    bus.q_clr_i = 1'b1;
    tick();
    bus.q_clr_i = 1'b0;
  endtask
  initial begin
    bus.q_en_i = 1'b0;
    bus.msg_type_mask_i = 16'h0001;
    bus.rxts_trig_i = 1'b0;
    bus.rxts_valid_i = 1'b0;
    bus.sfd_timestamp_i = '0;
    bus.rx_sourcePortIdentity_i = SPID;
    bus.rx_seqId_i = '0;
    bus.rx_messageType_i = '0;
    bus.rx_majorSdoId_i = '0;
    bus.q_pop_i = 1'b0;
    bus.q_clr_i = 1'b0;
    tick(2);
    chk("rst_valid", 184'(bus.q_valid_o), 184'(0));
    chk("rst_int", 184'(bus.int_rx_ts_o), 184'(0));
    chk("rst_count", 184'(bus.q_count_o), 184'(0));
    chk("rst_drop", 184'(bus.q_drop_cnt_o), 184'(0));
    chk("rst_ovf", 184'(bus.q_overflow_o), 184'(0));
    chk("rst_ts", 184'(bus.q_timestamp_o), 184'(0));
    rst_n = 1'b1;
    bus.q_en_i = 1'b1;
    tick();
    // basic capture and latency
    trig(80'h000000000001_00000100);
    tick(4);
    chk("t1_pre_valid", 184'(bus.q_valid_o), 184'(0));
    valid(16'h0042, 4'h0);
    chk("t1_valid", 184'(bus.q_valid_o), 184'(1));
    chk("t1_int", 184'(bus.int_rx_ts_o), 184'(1));
    chk("t1_ts", 184'(bus.q_timestamp_o), 184'(80'h000000000001_00000100));
    chk("t1_seq", 184'(bus.q_seqId_o), 184'(16'h0042));
    chk("t1_spid", 184'(bus.q_sourcePortIdentity_o), 184'(SPID));
    chk("t1_sdo", 184'(bus.q_majorSdoId_o), 184'(4'h3));
    chk("t1_count", 184'(bus.q_count_o), 184'(1));
    pop();
    chk("t1_empty", 184'(bus.q_valid_o), 184'(0));
    pop();
    chk("pop_empty_count", 184'(bus.q_count_o), 184'(0));
    // overflow: five pushes into four entries
    for (int i = 0; i < 5; i++) begin
      trig(80'(i + 16));
      valid(16'h0100 + 16'(i), 4'h0);
    end
    chk("t2_count", 184'(bus.q_count_o), 184'(4));
    chk("t2_drop", 184'(bus.q_drop_cnt_o), 184'(1));
    chk("t2_ovf", 184'(bus.q_overflow_o), 184'(1));
    for (int i = 0; i < 4; i++) begin
      chk("t2_seq_order", 184'(bus.q_seqId_o), 184'(16'h0100 + 16'(i)));
      chk("t2_ts_order", 184'(bus.q_timestamp_o), 184'(i + 16));
      pop();
    end
    chk("t2_drained", 184'(bus.q_count_o), 184'(0));
    chk("t2_ovf_sticky", 184'(bus.q_overflow_o), 184'(1));
    clr();
    chk("t2_clr_drop", 184'(bus.q_drop_cnt_o), 184'(0));
    chk("t2_clr_ovf", 184'(bus.q_overflow_o), 184'(0));
    // timeout: last accepted valid is TMO cycles after trig, one more is too late
    trig(80'h77);
    tick(TMO + 1);
    valid(16'h0300, 4'h0);
    chk("t3_timeout_count", 184'(bus.q_count_o), 184'(0));
    trig(80'h78);
    tick(TMO - 1);
    valid(16'h0301, 4'h0);
    chk("t3_edge_count", 184'(bus.q_count_o), 184'(1));
    chk("t3_edge_ts", 184'(bus.q_timestamp_o), 184'(80'h78));
    pop();
    // relatch and same-cycle trig+valid
    trig(80'hAAAA);
    trig(80'hBBBB);
    bus.rxts_trig_i = 1'b1;
    bus.sfd_timestamp_i = 80'hCCCC;
    valid(16'h0055, 4'h0);
    bus.rxts_trig_i = 1'b0;
    chk("t4_count1", 184'(bus.q_count_o), 184'(1));
    chk("t4_ts_b", 184'(bus.q_timestamp_o), 184'(80'hBBBB));
    valid(16'h0056, 4'h0);
    chk("t4_count2", 184'(bus.q_count_o), 184'(2));
    pop();
    chk("t4_ts_c", 184'(bus.q_timestamp_o), 184'(80'hCCCC));
    chk("t4_seq_c", 184'(bus.q_seqId_o), 184'(16'h0056));
    pop();
    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      trig(80'(i + 32));
      valid(16'h0200 + 16'(i), 4'h0);
    end
    chk("t5_full", 184'(bus.q_count_o), 184'(4));
    trig(80'h24);
    bus.q_pop_i = 1'b1;
    valid(16'h0204, 4'h0);
    bus.q_pop_i = 1'b0;
    chk("t5_count", 184'(bus.q_count_o), 184'(4));
    chk("t5_drop", 184'(bus.q_drop_cnt_o), 184'(0));
    chk("t5_ovf", 184'(bus.q_overflow_o), 184'(0));
    for (int i = 1; i < 5; i++) begin
      chk("t5_seq_order", 184'(bus.q_seqId_o), 184'(16'h0200 + 16'(i)));
      pop();
    end
    chk("t5_drained", 184'(bus.q_valid_o), 184'(0));
    // message type mask, stray valid in IDLE, then clear
    trig(80'h40);
    valid(16'h0400, 4'h8);
    chk("t6_masked", 184'(bus.q_count_o), 184'(0));
    valid(16'h0401, 4'h0);
    chk("t6_idle_valid", 184'(bus.q_count_o), 184'(0));
    for (int i = 0; i < 3; i++) begin
      trig(80'(i + 48));
      valid(16'h0500 + 16'(i), 4'h0);
    end
    chk("t6_count3", 184'(bus.q_count_o), 184'(3));
    clr();
    chk("t6_clr_count", 184'(bus.q_count_o), 184'(0));
    chk("t6_clr_valid", 184'(bus.q_valid_o), 184'(0));
    // disabled queue neither arms nor pushes
    bus.q_en_i = 1'b0;
    trig(80'h60);
    valid(16'h0600, 4'h0);
    chk("en_off_count", 184'(bus.q_count_o), 184'(0));
    bus.q_en_i = 1'b1;
    // asynchronous reset mid-frame
    trig(80'h70);
    valid(16'h0700, 4'h0);
    trig(80'h71);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 184'(bus.q_count_o), 184'(0));
    tick();
    rst_n = 1'b1;
    valid(16'h0701, 4'h0);
    chk("arst_no_push", 184'(bus.q_count_o), 184'(0));
    chk("arst_valid", 184'(bus.q_valid_o), 184'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
